// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requestor memory port arbiter.
// Holds the default address/data widths, the port identifier used by the
// round-robin pointer and read tags, and the read-tag payload.
// Optional build macro: MEM_ARB_STATS_EN (grant counters in mem_port_arbiter).
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 16;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry read response holding register for a single requestor.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   issue_i       - a read for this port was granted this cycle
//   capture_i     - returning RAM data for this port is valid this cycle
//   data_i        - returning RAM data
//   rready_i      - requestor accepts the held response
//   rvalid_o      - response valid (registered)
//   rdata_o       - response data (registered)
//   busy_c        - read in flight or held; blocks further reads
module mem_arb_rsp_slot
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic              capture_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rready_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_c
);

    logic inflight_q;

    // In-flight flag covers grant until the data lands in the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rvalid_o   <= 1'b0;
            rdata_o    <= '0;
        end else begin
            if (issue_i) begin
                inflight_q <= 1'b1;
            end else if (capture_i) begin
                inflight_q <= 1'b0;
            end

            if (capture_i) begin
                rvalid_o <= 1'b1;
                rdata_o  <= data_i;
            end else if (rvalid_o && rready_i) begin
                rvalid_o <= 1'b0;
            end
        end
    end

    assign busy_c = inflight_q | rvalid_o;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of two requestors onto one single-port RAM bank, with a
// tagged synchronous-read return path and per-port held read responses.
// Ports:
//   clk_pi, rst_pi                      - clock, asynchronous active-high reset
//   req/we/addr/data_{a,b}_i            - requests, held until granted
//   gnt_{a,b}_o                         - combinational grant
//   rvalid/rdata_{a,b}_o, rready_{a,b}_i - read response handshake
//   ram_addr/data/en/we_o, ram_data_i   - RAM bank interface
//   gnt_cnt_{a,b}_o                     - saturating grant counters, only
//                                         when MEM_ARB_STATS_EN is defined
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic              req_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] data_a_i,
    output logic              gnt_a_o,
    output logic              rvalid_a_o,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              rready_a_i,
    input  logic              req_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] data_b_i,
    output logic              gnt_b_o,
    output logic              rvalid_b_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              rready_b_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_data_i
`ifdef MEM_ARB_STATS_EN
   ,output logic [CNT_W-1:0]  gnt_cnt_a_o,
    output logic [CNT_W-1:0]  gnt_cnt_b_o
`endif
);

    port_id_e rr_q;
    rd_tag_t  tag0_q;
    rd_tag_t  tag1_q;
    logic     busy_a;
    logic     busy_b;
    logic     elig_a;
    logic     elig_b;
    logic     cap_a;
    logic     cap_b;

    // Writes never wait on the response slot; reads need an idle slot.
    always_comb begin
        elig_a  = req_a_i & (we_a_i | ~busy_a);
        elig_b  = req_b_i & (we_b_i | ~busy_b);
        gnt_a_o = elig_a & (~elig_b | (rr_q == PORT_A));
        gnt_b_o = elig_b & (~elig_a | (rr_q == PORT_B));
    end

    // Issue stage, pointer update and two-stage read tag pipeline.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            rr_q       <= PORT_A;
            ram_en_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
        end else begin
            ram_en_o <= gnt_a_o | gnt_b_o;
            if (gnt_a_o) begin
                ram_we_o   <= we_a_i;
                ram_addr_o <= addr_a_i;
                ram_data_o <= data_a_i;
                rr_q       <= PORT_B;
            end else if (gnt_b_o) begin
                ram_we_o   <= we_b_i;
                ram_addr_o <= addr_b_i;
                ram_data_o <= data_b_i;
                rr_q       <= PORT_A;
            end
            tag0_q.valid <= (gnt_a_o & ~we_a_i) | (gnt_b_o & ~we_b_i);
            tag0_q.port  <= gnt_b_o ? PORT_B : PORT_A;
            tag1_q       <= tag0_q;
        end
    end

    // Second tag stage lines up with RAM read data on ram_data_i.
    assign cap_a = tag1_q.valid & (tag1_q.port == PORT_A);
    assign cap_b = tag1_q.valid & (tag1_q.port == PORT_B);

    mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot_a (
        .clk       (clk_pi),
        .rst       (rst_pi),
        .issue_i   (gnt_a_o & ~we_a_i),
        .capture_i (cap_a),
        .data_i    (ram_data_i),
        .rready_i  (rready_a_i),
        .rvalid_o  (rvalid_a_o),
        .rdata_o   (rdata_a_o),
        .busy_c    (busy_a)
    );

    mem_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot_b (
        .clk       (clk_pi),
        .rst       (rst_pi),
        .issue_i   (gnt_b_o & ~we_b_i),
        .capture_i (cap_b),
        .data_i    (ram_data_i),
        .rready_i  (rready_b_i),
        .rvalid_o  (rvalid_b_o),
        .rdata_o   (rdata_b_o),
        .busy_c    (busy_b)
    );

`ifdef MEM_ARB_STATS_EN
    // Saturating per-port grant counters.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            gnt_cnt_a_o <= '0;
            gnt_cnt_b_o <= '0;
        end else begin
            if (gnt_a_o && (gnt_cnt_a_o != {CNT_W{1'b1}})) begin
                gnt_cnt_a_o <= gnt_cnt_a_o + CNT_W'(1);
            end
            if (gnt_b_o && (gnt_cnt_b_o != {CNT_W{1'b1}})) begin
                gnt_cnt_b_o <= gnt_cnt_b_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule
